cla_nibble_sequencer: RTL
=========================

CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin one addition; sampled on the rising edge of clk.
REQ-005 Port: a, b  input  WIDTH  operands, captured on the accepted start.
REQ-006 Port: cin  input  1  carry into nibble 0, captured on the accepted start.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: done  output  1  one-cycle pulse when sum and cout become valid.
REQ-009 Port: sum  output  WIDTH  result; held from done until the next accepted start.
REQ-010 Port: cout  output  1  carry out of the top nibble; held with sum.
REQ-011 Port: stage_en  output  1  enable to the downstream registered 4-bit CLA stage.
REQ-012 Port: stage_a, stage_b  output  4  nibble operands driven to the stage.
REQ-013 Port: stage_cin  output  1  nibble carry-in driven to the stage.
REQ-014 Port: stage_q  input  5  registered stage result, {carry, sum[3:0]}; valid in the cycle after stage_en.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, CAPTURE and DONE; N = WIDTH/4 nibbles; k = nibble index, 0..N-1.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b and cin, clear k to 0, and move to ISSUE.
REQ-017 In IDLE or DONE, start=0 SHALL move to IDLE, or stay there.
REQ-018 ISSUE SHALL assert stage_en and drive stage_a=a[4k+3:4k], stage_b=b[4k+3:4k] and stage_cin (the latched cin for k=0, else the carry register), then move to CAPTURE.
REQ-019 CAPTURE SHALL write stage_q[3:0] into sum[4k+3:4k] and stage_q[4] into the carry register.
REQ-020 From CAPTURE, if k<N-1 the FSM SHALL increment k and return to ISSUE; otherwise it SHALL load cout from stage_q[4] and move to DONE.
REQ-021 done SHALL be 1 only in DONE; busy SHALL be 1 only in ISSUE and CAPTURE.
REQ-022 Latency: done SHALL be high exactly 2N+1 cycles after the cycle in which start is accepted (9 cycles for WIDTH=16).
REQ-023 start while busy=1 SHALL be ignored, with no effect on operands, sum or timing.
REQ-024 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-025 stage_en, stage_a, stage_b and stage_cin SHALL be 0 outside ISSUE.
REQ-026 sum SHALL wrap modulo 2^WIDTH; the carry beyond bit WIDTH-1 SHALL appear only on cout.
REQ-027 Changes on a, b and cin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-028 rst_n=0 SHALL immediately force the state to IDLE, and sum, cout, k, the carry register, busy, done and all stage_* outputs to 0.
REQ-029 Reset mid-operation SHALL abandon the operation; no done pulse SHALL follow it.
REQ-030 After rst_n is released, the first accepted start SHALL behave exactly as from power-up.

Configuration
REQ-031 Macro CLA_SEQ_SUB_EN, when defined, SHALL add input op (1 bit, captured on the accepted start).
REQ-032 With CLA_SEQ_SUB_EN and op=1, the block SHALL compute a-b: stage_b = inverted b nibbles, nibble-0 carry-in forced to 1, and cin ignored; cout=1 means no borrow.
REQ-033 Without CLA_SEQ_SUB_EN, the op port SHALL be absent and the block SHALL only add.

Structure
REQ-034 Shared package cla_seq_pkg SHALL hold the FSM state enum typedef and the constant NIB_W=4.
REQ-035 The block SHALL have no sub-module; the registered 4-bit CLA stage SHALL be external, connected through the stage_* ports.

Verification
REQ-036 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, done exactly 9 cycles after start.
REQ-037 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; stage_en pulses 4 times, 2 cycles apart.
REQ-038 start re-asserted on cycles 3-5 of an operation -> ignored; single done at cycle 9 with the original result.
REQ-039 rst_n pulsed low on cycle 4 -> all outputs 0 at once; no done; the next start 0x0001+0x0001 gives 0x0002.
REQ-040 start held high through DONE with a second operand pair 0x8000+0x8000 -> second done 9 cycles later, sum=0x0000, cout=1.
REQ-041 (CLA_SEQ_SUB_EN) op=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial CLA sequencer: nibble width and FSM state encoding.
package cla_seq_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial adder: streams WIDTH/4 nibbles through an external registered 4-bit CLA stage.
// Optional macro CLA_SEQ_SUB_EN adds an 'op' input selecting a-b instead of a+b+cin.
module cla_nibble_sequencer
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                 op,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic                 stage_en,
    output logic [NIB_W-1:0]     stage_a,
    output logic [NIB_W-1:0]     stage_b,
    output logic                 stage_cin,
    input  logic [NIB_W:0]       stage_q
);

    localparam int unsigned N   = WIDTH / NIB_W;
    localparam int unsigned K_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = {{(WIDTH - NIB_W){1'b0}}, {NIB_W{1'b1}}};

    seq_state_e           state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 cin_q, cin_d;
    logic                 carry_q, carry_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stage_en_q, stage_en_d;
    logic [NIB_W-1:0]     stage_a_q, stage_a_d;
    logic [NIB_W-1:0]     stage_b_q, stage_b_d;
    logic                 stage_cin_q, stage_cin_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_en_q  <= 1'b0;
            stage_a_q   <= '0;
            stage_b_q   <= '0;
            stage_cin_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_en_q  <= stage_en_d;
            stage_a_q   <= stage_a_d;
            stage_b_q   <= stage_b_d;
            stage_cin_q <= stage_cin_d;
        end
    end

    // Next state, operand capture, nibble write-back and registered output decode
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        stage_en_d  = 1'b0;
        stage_a_d   = '0;
        stage_b_d   = '0;
        stage_cin_d = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    k_d     = '0;
                    state_d = ISSUE;
`ifdef CLA_SEQ_SUB_EN
                    // Subtract as a + ~b + 1; cout then reads as "no borrow"
                    b_d     = op ? ~b : b;
                    cin_d   = op ? 1'b1 : cin;
`else
                    b_d     = b;
                    cin_d   = cin;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                sum_d   = (sum_q & ~(NIB_MASK << (NIB_W * k_q)))
                        | (WIDTH'(stage_q[NIB_W-1:0]) << (NIB_W * k_q));
                carry_d = stage_q[NIB_W];
                if (k_q != K_LAST) begin
                    k_d     = k_q + K_W'(1);
                    state_d = ISSUE;
                end else begin
                    cout_d  = stage_q[NIB_W];
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register
        busy_d = (state_d == ISSUE) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
        if (state_d == ISSUE) begin
            stage_en_d  = 1'b1;
            stage_a_d   = NIB_W'(a_d >> (NIB_W * k_d));
            stage_b_d   = NIB_W'(b_d >> (NIB_W * k_d));
            stage_cin_d = (k_d == '0) ? cin_d : carry_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign stage_en  = stage_en_q;
    assign stage_a   = stage_a_q;
    assign stage_b   = stage_b_q;
    assign stage_cin = stage_cin_q;

endmodule
